regs: RTL and testbench
=======================

Name: regs

Overview:
- Architectural integer register file for the 5-stage RV32I pipeline.
- Consumer end of the write-back interface: it accepts result/address pairs from the write-back stage and commits them to 32 x 32-bit registers.
- Supplies two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards on in-flight producers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- RESET_VAL, 32'h0, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_reg_we_i  input  1  write-back write enable.
- wb_reg_waddr_i  input  ADDR_W  write-back destination register.
- wb_op_c_i  input  DATA_W  write-back result data.
- id_raddr1_i  input  ADDR_W  decode read address, port 1 (rs1).
- id_raddr2_i  input  ADDR_W  decode read address, port 2 (rs2).
- id_issue_i  input  1  decode issues an instruction that writes rd.
- id_issue_rd_i  input  ADDR_W  destination of the issuing instruction.
- regs_rdata1_o  output  DATA_W  read data, port 1.
- regs_rdata2_o  output  DATA_W  read data, port 2.
- regs_busy1_o  output  1  rs1 has an outstanding producer.
- regs_busy2_o  output  1  rs2 has an outstanding producer.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (rst_n=0, asynchronous):
  - all registers take RESET_VAL;
  - all busy bits clear;
  - outputs then follow the read rules below, giving RESET_VAL (x0 gives 0) and busy=0.
  - Reset asserted mid-operation discards any same-cycle write or issue.
- Write:
  - On rising clk with wb_reg_we_i=1 and wb_reg_waddr_i!=0, reg[waddr] <= wb_op_c_i.
  - Writes to x0 are ignored.
  - Write latency is 1 cycle to storage.
- Read:
  - Combinational.
  - rdataN = 0 if raddrN==0.
  - Otherwise rdataN = wb_op_c_i if wb_reg_we_i && wb_reg_waddr_i==raddrN (bypass).
  - Otherwise rdataN = reg[raddrN].
  - Both ports are independent; identical addresses on both ports return identical data.
- Scoreboard: busy[31:1] flops; busy[0] is constant 0.
  - Set: id_issue_i=1 && id_issue_rd_i!=0 sets busy[id_issue_rd_i] at the clock edge.
  - Clear: wb_reg_we_i=1 && wb_reg_waddr_i!=0 clears busy[wb_reg_waddr_i] at the clock edge.
  - Set and clear of the same register in the same cycle: set wins (the newer producer is outstanding).
  - Set and clear of different registers in the same cycle: both take effect.
  - Setting an already-busy register leaves it busy (single bit, no count). Decode must stall rather than issue a second writer to a busy rd.
- Busy outputs:
  - regs_busyN_o = busy[raddrN], masked to 0 when the bypass condition for that port holds (the value is available this cycle).
  - Masked to 0 when raddrN==0.
- No internal state machine beyond storage and scoreboard; no handshake back-pressure. The write port always accepts.

Optional Feature:
- Macro: REGS_DEBUG_PORT_EN.
- Defined: adds ports dbg_raddr_i (input, ADDR_W), dbg_rdata_o (output, DATA_W) and dbg_busy_o (output, 1).
  - Read semantics are identical to ports 1/2, including bypass and x0=0.
  - dbg_busy_o = raw busy bit, unmasked.
  - Used by the debug module for register dumps.
- Not defined: these ports do not exist; no extra logic.

Test Plan:
- Reset, then read x0..x31 on both ports -> all rdata 0, all busy 0.
- Write x5=32'hDEADBEEF; next cycle read rs1=x5, rs2=x5 -> both 32'hDEADBEEF.
- Write x0=32'hFFFFFFFF; read x0 -> 0, busy 0.
- Bypass:
  - Setup: in the same cycle, we=1, waddr=x7, data=32'h12345678, with rs1=x7; reg x7 previously held 32'h0.
  - Same cycle: rdata1=32'h12345678.
  - Next cycle: still 32'h12345678.
- Scoreboard:
  - Issue rd=x9 -> busy1=1 for rs1=x9 next cycle.
  - In the cycle where the x9 write-back occurs, busy1=0 (masked).
  - After that edge, busy stays 0.
  - Same-cycle issue rd=x9 plus write-back x9 -> busy remains 1.
- Assert rst_n low while busy[3]=1 and a write to x3 is pending -> x3=0, busy[3]=0 immediately; the write is not committed.

Source files
------------

// File: rtl/regs.sv
`timescale 1ns/1ps
// regs: RV32I integer register file with two bypassed read ports and a RAW busy scoreboard; REGS_DEBUG_PORT_EN adds a debug read port.
// Latency: reads are combinational; writes and scoreboard updates become visible one clk after the edge.
// Backpressure: none; write-back and issue are always accepted.
module regs #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_reg_we_i,
  input  logic [ADDR_W-1:0] wb_reg_waddr_i,
  input  logic [DATA_W-1:0] wb_op_c_i,
  input  logic [ADDR_W-1:0] id_raddr1_i,
  input  logic [ADDR_W-1:0] id_raddr2_i,
  input  logic              id_issue_i,
  input  logic [ADDR_W-1:0] id_issue_rd_i,
  output logic [DATA_W-1:0] regs_rdata1_o,
  output logic [DATA_W-1:0] regs_rdata2_o,
  output logic              regs_busy1_o,
  output logic              regs_busy2_o
`ifdef REGS_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_busy_o
`endif
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic wr_en;
  logic iss_en;
  logic byp1;
  logic byp2;

  assign wr_en  = wb_reg_we_i && (wb_reg_waddr_i != '0);
  assign iss_en = id_issue_i && (id_issue_rd_i != '0);
  // wr_en already excludes x0, so a match implies a non-zero read address
  assign byp1   = wr_en && (wb_reg_waddr_i == id_raddr1_i);
  assign byp2   = wr_en && (wb_reg_waddr_i == id_raddr2_i);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wb_reg_waddr_i] = wb_op_c_i;
    end
  end

  // Clear before set so a new producer issued alongside the old one's write-back stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wb_reg_waddr_i] = 1'b0;
    end
    if (iss_en) begin
      busy_d[id_issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= RESET_VAL;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    regs_rdata1_o = mem_q[id_raddr1_i];
    regs_busy1_o  = busy_q[id_raddr1_i];
    if (id_raddr1_i == '0) begin
      regs_rdata1_o = '0;
      regs_busy1_o  = 1'b0;
    end else if (byp1) begin
      regs_rdata1_o = wb_op_c_i;
      regs_busy1_o  = 1'b0;
    end
  end

  always_comb begin
    regs_rdata2_o = mem_q[id_raddr2_i];
    regs_busy2_o  = busy_q[id_raddr2_i];
    if (id_raddr2_i == '0) begin
      regs_rdata2_o = '0;
      regs_busy2_o  = 1'b0;
    end else if (byp2) begin
      regs_rdata2_o = wb_op_c_i;
      regs_busy2_o  = 1'b0;
    end
  end

`ifdef REGS_DEBUG_PORT_EN
  logic bypd;
  assign bypd = wr_en && (wb_reg_waddr_i == dbg_raddr_i);

  // Debug sees the raw busy bit so a dump shows producers even while their result is on the bypass.
  always_comb begin
    dbg_rdata_o = mem_q[dbg_raddr_i];
    dbg_busy_o  = busy_q[dbg_raddr_i];
    if (dbg_raddr_i == '0) begin
      dbg_rdata_o = '0;
    end else if (bypd) begin
      dbg_rdata_o = wb_op_c_i;
    end
  end
`endif

endmodule

// File: tb/tb_regs.sv
`timescale 1ns/1ps
// Self-checking bench for regs: directed scenarios plus randomized traffic against a behavioural model.
module tb_regs;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic        iss;
  logic [4:0]  rd;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;
`ifdef REGS_DEBUG_PORT_EN
  logic [4:0]  dbg_a;
  logic [31:0] dbg_rdata;
  logic        dbg_busy;
`endif

  int checks = 0;
  int passed = 0;

  logic [31:0] model_reg [32];
  logic        model_busy [32];

  regs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_reg_we_i    (we),
    .wb_reg_waddr_i (waddr),
    .wb_op_c_i      (wdata),
    .id_raddr1_i    (r1),
    .id_raddr2_i    (r2),
    .id_issue_i     (iss),
    .id_issue_rd_i  (rd),
    .regs_rdata1_o  (rdata1),
    .regs_rdata2_o  (rdata2),
    .regs_busy1_o   (busy1),
    .regs_busy2_o   (busy2)
`ifdef REGS_DEBUG_PORT_EN
    ,
    .dbg_raddr_i    (dbg_a),
    .dbg_rdata_o    (dbg_rdata),
    .dbg_busy_o     (dbg_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rdata(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model_reg[a];
  endfunction

  function automatic logic ref_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (we && waddr == a) return 1'b0;
    return model_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model_reg[i]  = 32'h0;
      model_busy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic is, input logic [4:0] ird);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; r1 = a1; r2 = a2; iss = is; rd = ird;
    #1;
  endtask

  // Apply the architectural effect of the currently driven inputs, then take the edge.
  task automatic commit();
    if (rst_n) begin
      if (we && waddr != 0) begin
        model_reg[waddr]  = wdata;
        model_busy[waddr] = 1'b0;
      end
      if (iss && rd != 0) model_busy[rd] = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      checks++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 x%0d got %h want 0", a, rdata1); else passed++;
      checks++; if (rdata2 !== 32'h0) $display("FAIL reset_rdata2 x%0d got %h want 0", 31 - a, rdata2); else passed++;
      checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 x%0d got %b want 0", a, busy1); else passed++;
      checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 x%0d got %b want 0", 31 - a, busy2); else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    checks++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL wr_rd_port1 got %h want deadbeef", rdata1); else passed++;
    checks++; if (rdata2 !== 32'hDEADBEEF) $display("FAIL wr_rd_port2 got %h want deadbeef", rdata2); else passed++;
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
    checks++; if (rdata1 !== 32'h0) $display("FAIL x0_bypass got %h want 0", rdata1); else passed++;
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    checks++; if (rdata1 !== 32'h0) $display("FAIL x0_read got %h want 0", rdata1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL x0_busy got %b want 0", busy1); else passed++;
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd8, 1'b0, 5'd0);
    checks++; if (rdata1 !== 32'h12345678) $display("FAIL bypass_same got %h want 12345678", rdata1); else passed++;
    checks++; if (rdata2 !== 32'h0) $display("FAIL bypass_other got %h want 0", rdata2); else passed++;
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
    checks++; if (rdata1 !== 32'h12345678) $display("FAIL bypass_next got %h want 12345678", rdata1); else passed++;
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    checks++; if (busy1 !== 1'b1) $display("FAIL sb_set1 got %b want 1", busy1); else passed++;
    checks++; if (busy2 !== 1'b1) $display("FAIL sb_set2 got %b want 1", busy2); else passed++;
    drive(1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd9, 1'b0, 5'd0);
    checks++; if (busy1 !== 1'b0) $display("FAIL sb_mask got %b want 0", busy1); else passed++;
    checks++; if (rdata1 !== 32'hCAFE0009) $display("FAIL sb_wb_data got %h want cafe0009", rdata1); else passed++;
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    checks++; if (busy1 !== 1'b0) $display("FAIL sb_clear got %b want 0", busy1); else passed++;
    drive(1'b1, 5'd9, 32'h0BAD0009, 5'd0, 5'd0, 1'b1, 5'd9);
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    checks++; if (busy1 !== 1'b1) $display("FAIL sb_set_wins got %b want 1", busy1); else passed++;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd11);
    commit();
    drive(1'b1, 5'd11, 32'h11, 5'd0, 5'd0, 1'b1, 5'd10);
    commit();
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b0, 5'd0);
    checks++; if (busy1 !== 1'b1) $display("FAIL sb_diff_set got %b want 1", busy1); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL sb_diff_clr got %b want 0", busy2); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 3) == 0), 5'($urandom));
`ifdef REGS_DEBUG_PORT_EN
      dbg_a = 5'($urandom);
      #1;
      checks++; if (dbg_rdata !== ref_rdata(dbg_a)) $display("FAIL rnd_dbg_rdata n=%0d got %h want %h", n, dbg_rdata, ref_rdata(dbg_a)); else passed++;
      checks++; if (dbg_busy !== (dbg_a != 0 && model_busy[dbg_a])) $display("FAIL rnd_dbg_busy n=%0d got %b", n, dbg_busy); else passed++;
`endif
      checks++; if (rdata1 !== ref_rdata(r1)) $display("FAIL rnd_rdata1 n=%0d got %h want %h", n, rdata1, ref_rdata(r1)); else passed++;
      checks++; if (rdata2 !== ref_rdata(r2)) $display("FAIL rnd_rdata2 n=%0d got %h want %h", n, rdata2, ref_rdata(r2)); else passed++;
      checks++; if (busy1 !== ref_busy(r1)) $display("FAIL rnd_busy1 n=%0d got %b want %b", n, busy1, ref_busy(r1)); else passed++;
      checks++; if (busy2 !== ref_busy(r2)) $display("FAIL rnd_busy2 n=%0d got %b want %b", n, busy2, ref_busy(r2)); else passed++;
      commit();
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3);
    commit();
    drive(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, 1'b1, 5'd4);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rdata1 !== 32'hAAAA5555) $display("FAIL rst_bypass got %h want aaaa5555", rdata1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL rst_busy_imm got %b want 0", busy1); else passed++;
    @(posedge clk);
    #1;
    we = 1'b0; iss = 1'b0; r2 = 5'd4;
    #1;
    checks++; if (rdata1 !== 32'h0) $display("FAIL rst_x3_data got %h want 0", rdata1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL rst_x3_busy got %b want 0", busy1); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL rst_x4_busy got %b want 0", busy2); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0, 5'd0);
    checks++; if (rdata1 !== 32'h0) $display("FAIL post_rst_x3 got %h want 0", rdata1); else passed++;
    checks++; if (rdata2 !== 32'h0) $display("FAIL post_rst_x5 got %h want 0", rdata2); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; r1 = '0; r2 = '0; iss = 1'b0; rd = '0;
`ifdef REGS_DEBUG_PORT_EN
    dbg_a = '0;
`endif
    model_reset();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
